axis_s_pkt_buf: RTL
===================

AXIS_S_PKT_BUF -- requirements
Module: axis_s_pkt_buf

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, the tdata/dout width in bits (legal range 1..64).
REQ-002 The block SHALL provide parameter DEPTH, default 16, the FIFO depth in beats (power of two, legal range 2..256).
REQ-003 The block SHALL use a single clock and a synchronous, active-low reset: s_axis_aclk and s_axis_aresetn.
REQ-004 s_axis_aclk  input  1  clock; all state updates on its rising edge.
REQ-005 s_axis_aresetn  input  1  synchronous active-low reset.
REQ-006 s_axis_tvalid  input  1  upstream beat valid.
REQ-007 s_axis_tdata  input  DATA_W  upstream beat data.
REQ-008 s_axis_tlast  input  1  upstream last beat of packet.
REQ-009 s_axis_tready  output  1  block can accept a beat.
REQ-010 rd_en  input  1  consumer pops the head beat.
REQ-011 dout  output  DATA_W  head-of-FIFO data.
REQ-012 dout_last  output  1  head-of-FIFO tlast flag.
REQ-013 dout_valid  output  1  FIFO non-empty; dout/dout_last meaningful.
REQ-014 level  output  $clog2(DEPTH)+1  current beat occupancy, 0..DEPTH.
REQ-015 in_packet  output  1  a packet has started and its tlast beat has not been accepted.
REQ-016 pkt_cnt  output  16  accepted complete packets (see Configuration).

Function
REQ-017 s_axis_tready SHALL equal (level != DEPTH) and SHALL be derived only from registered state, with no combinational path from s_axis_tvalid.
REQ-018 A beat SHALL be accepted exactly on a rising edge where s_axis_tvalid && s_axis_tready; {tlast, tdata} is written at the write pointer, and the write pointer advances modulo DEPTH.
REQ-019 The FIFO SHALL operate first-word-fall-through: dout = data at the read pointer, dout_last = tlast at the read pointer, dout_valid = (level != 0).
REQ-020 A beat accepted at edge N SHALL appear on dout with dout_valid=1 in the cycle following edge N when the FIFO was empty (one-cycle latency).
REQ-021 A pop SHALL occur on a rising edge where rd_en && dout_valid; the read pointer advances modulo DEPTH; rd_en with dout_valid=0 SHALL be ignored.
REQ-022 A simultaneous accept and pop SHALL leave level unchanged, including at level==DEPTH-1 and level==1.
REQ-023 When full, s_axis_tready=0, so there is no accept; a pop in that cycle SHALL drop level to DEPTH-1, and tready SHALL rise in the next cycle.
REQ-024 The packet FSM SHALL have states IDLE and BODY: IDLE->BODY on an accepted beat with tlast=0; BODY->IDLE on an accepted beat with tlast=1; any other event holds the state; a single-beat packet (tlast=1 in IDLE) stays in IDLE.
REQ-025 in_packet SHALL be 1 exactly when the FSM is in BODY.
REQ-026 Data values SHALL pass through unmodified; no width conversion is performed.

Reset
REQ-027 While s_axis_aresetn=0 at a rising edge, the block SHALL clear the pointers and level to 0, set the FSM to IDLE, and set pkt_cnt to 0; FIFO memory contents are not cleared.
REQ-028 During reset and in the cycle after release, outputs SHALL be s_axis_tready=0 during reset then 1 after, dout_valid=0, level=0, and in_packet=0; dout/dout_last are don't-care while dout_valid=0.
REQ-029 Reset mid-packet SHALL discard all buffered beats and the partial packet; no beat SHALL be accepted on an edge where reset is asserted.

Configuration
REQ-030 With macro AXIS_S_PKT_CNT_EN defined, pkt_cnt SHALL increment by 1 on each accepted beat with s_axis_tlast=1 and wrap from 65535 to 0.
REQ-031 Without AXIS_S_PKT_CNT_EN, the pkt_cnt port SHALL remain present, be driven constant 0, and the counter logic SHALL not be built.

Structure
REQ-032 Package axis_s_pkg SHALL hold the FSM state enum (IDLE, BODY) and the constant PKT_CNT_W=16.
REQ-033 Storage SHALL be the sub-module axis_s_fifo_mem (DEPTH x (DATA_W+1), one synchronous write port, one asynchronous read port); pointers, level, and FSM stay in axis_s_pkt_buf.

Verification
REQ-034 Reset then idle: after 5 cycles of reset -> tready=1, dout_valid=0, level=0, pkt_cnt=0.
REQ-035 Ten beats 0x01..0x0A with tlast on 0x0A, rd_en=0 -> level=10, in_packet toggles 1 then 0, pkt_cnt=1 (macro on); popping yields 0x01..0x0A in order with dout_last=1 only on 0x0A.
REQ-036 Fill DEPTH=16 beats without popping -> tready=0 at level=16 and a 17th beat is held; one pop -> level=15, and the next cycle tready=1 and the held beat is accepted.
REQ-037 Continuous tvalid=1 and rd_en=1 from level=1 for 20 cycles -> level stays 1, and output order matches input order.
REQ-038 Reset asserted after 3 beats of a 6-beat packet -> level=0, in_packet=0, pkt_cnt=0; a following 1-beat packet with tlast=1 -> pkt_cnt=1, in_packet stays 0.
REQ-039 Compiled without AXIS_S_PKT_CNT_EN, the REQ-035 stimulus -> pkt_cnt=0 throughout, with all other responses identical.

Source files
------------

// File: rtl/axis_s_pkg.sv
// Shared types and constants for the AXI-Stream slave packet buffer.
package axis_s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } pkt_state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_s_fifo_mem.sv
// Beat storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
module axis_s_fifo_mem
  import axis_s_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_s_pkt_buf.sv
// AXI-Stream slave packet buffer: FWFT FIFO with packet-boundary tracking.
// Optional packet counter enabled by defining AXIS_S_PKT_CNT_EN.
module axis_s_pkt_buf
  import axis_s_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  input  logic                 s_axis_tvalid,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_last,
  output logic                 dout_valid,
  output logic [LW-1:0]        level,
  output logic                 in_packet,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          ready_q;
  logic          accept;
  logic          pop;
  pkt_state_t    state;
  pkt_state_t    state_nxt;

  // ready_q holds tready low while in reset without adding a path from tvalid.
  assign s_axis_tready = ready_q && (level_q != LW'(DEPTH));
  assign dout_valid    = (level_q != '0);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign pop           = rd_en && dout_valid;
  assign level         = level_q;
  assign in_packet     = (state == BODY);

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !s_axis_tlast) state_nxt = BODY;
      BODY:    if (accept && s_axis_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  axis_s_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (s_axis_aclk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr),
    .rdata ({dout_last, dout})
  );

`ifdef AXIS_S_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  // Counts tlast beats at acceptance; wraps naturally at 2^PKT_CNT_W.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      pkt_cnt_q <= '0;
    end else if (accept && s_axis_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule
